// File: rtl/pipeline_stall_ctrl_if.sv
// Handshake bundle between the hazard detector, decode and the pipeline stall/flush controller.
// The master side drives hazard/decode flags; the slave side (controller) drives enables, release pulses and counters.
interface pipeline_stall_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             data_hazard;
  logic             control_hazard;
  logic             call;
  logic             ret;
  logic             branch;
  logic             cnt_clr;
  logic             pc_write_en;
  logic             ifid_write_en;
  logic             ifid_flush;
  logic             idex_bubble;
  logic             clr_call_haz;
  logic             clr_ret_haz;
  logic             clr_branch_haz;
  logic [CNT_W-1:0] data_stall_cnt;
  logic [CNT_W-1:0] ctrl_stall_cnt;
  logic             hazard_err;

  modport master (
    output data_hazard, control_hazard, call, ret, branch, cnt_clr,
    input  pc_write_en, ifid_write_en, ifid_flush, idex_bubble,
    input  clr_call_haz, clr_ret_haz, clr_branch_haz,
    input  data_stall_cnt, ctrl_stall_cnt, hazard_err
  );

  modport slave (
    input  data_hazard, control_hazard, call, ret, branch, cnt_clr,
    output pc_write_en, ifid_write_en, ifid_flush, idex_bubble,
    output clr_call_haz, clr_ret_haz, clr_branch_haz,
    output data_stall_cnt, ctrl_stall_cnt, hazard_err
  );
endinterface

// File: rtl/pipeline_stall_ctrl.sv
// Front-end stall/flush controller: data-hazard bubbles, timed control-transfer waits with
// one-cycle hazard release pulses, and saturating stall-cycle counters for performance debug.
module pipeline_stall_ctrl #(
  parameter int CALL_CYCLES   = 2,
  parameter int RET_CYCLES    = 3,
  parameter int BRANCH_CYCLES = 2,
  parameter int CNT_W         = 16
) (
  input logic                 clk,
  input logic                 rst,
  pipeline_stall_ctrl_if.slave bus
);

  localparam logic [0:0] S_RUN  = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;

  localparam logic [1:0] CT_NONE = 2'd0;
  localparam logic [1:0] CT_CALL = 2'd1;
  localparam logic [1:0] CT_RET  = 2'd2;
  localparam logic [1:0] CT_BR   = 2'd3;

  localparam logic [3:0] CALL_LD = 4'(CALL_CYCLES - 1);
  localparam logic [3:0] RET_LD  = 4'(RET_CYCLES - 1);
  localparam logic [3:0] BR_LD   = 4'(BRANCH_CYCLES - 1);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [0:0]       state;
  logic [3:0]       wait_cnt;
  logic [1:0]       ctrl_type;
  logic [CNT_W-1:0] r_data_cnt;
  logic [CNT_W-1:0] r_ctrl_cnt;
  logic             r_err;

  logic             w_run;
  logic             w_last;
  logic             w_accept;
  logic [1:0]       w_type;
  logic [3:0]       w_ld;

  assign w_run    = (state == S_RUN);
  assign w_last   = (state == S_WAIT) && (wait_cnt == 4'd0);
  assign w_accept = w_run && !bus.data_hazard && (bus.call || bus.ret || bus.branch);

  // ret > call > branch when several decode flags are raised together
  always_comb begin
    w_type = CT_BR;
    w_ld   = BR_LD;
    if (bus.ret) begin
      w_type = CT_RET;
      w_ld   = RET_LD;
    end else if (bus.call) begin
      w_type = CT_CALL;
      w_ld   = CALL_LD;
    end
  end

  // Enables are purely combinational so a stall takes effect in the same cycle
  always_comb begin
    bus.pc_write_en    = 1'b0;
    bus.ifid_write_en  = 1'b0;
    bus.ifid_flush     = 1'b1;
    bus.idex_bubble    = 1'b1;
    bus.clr_call_haz   = 1'b0;
    bus.clr_ret_haz    = 1'b0;
    bus.clr_branch_haz = 1'b0;
    if (!rst) begin
      if (w_run) begin
        bus.ifid_flush    = 1'b0;
        bus.pc_write_en   = !bus.data_hazard;
        bus.ifid_write_en = !bus.data_hazard;
        bus.idex_bubble   = bus.data_hazard;
      end else begin
        bus.ifid_flush     = 1'b1;
        bus.ifid_write_en  = 1'b1;
        bus.idex_bubble    = 1'b0;
        bus.pc_write_en    = w_last;
        bus.clr_call_haz   = w_last && (ctrl_type == CT_CALL);
        bus.clr_ret_haz    = w_last && (ctrl_type == CT_RET);
        bus.clr_branch_haz = w_last && (ctrl_type == CT_BR);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_RUN;
      wait_cnt   <= 4'd0;
      ctrl_type  <= CT_NONE;
      r_data_cnt <= '0;
      r_ctrl_cnt <= '0;
      r_err      <= 1'b0;
    end else begin
      if (w_run) begin
        if (w_accept) begin
          state     <= S_WAIT;
          ctrl_type <= w_type;
          wait_cnt  <= w_ld;
        end
      end else begin
        if (!bus.control_hazard)
          r_err <= 1'b1;
        if (wait_cnt == 4'd0)
          state <= S_RUN;
        else
          wait_cnt <= wait_cnt - 4'd1;
      end

      // clear wins over a same-cycle increment
      if (bus.cnt_clr) begin
        r_data_cnt <= '0;
        r_ctrl_cnt <= '0;
      end else begin
        if (w_run && bus.data_hazard && (r_data_cnt != CNT_MAX))
          r_data_cnt <= r_data_cnt + 1'b1;
        if (!w_run && (r_ctrl_cnt != CNT_MAX))
          r_ctrl_cnt <= r_ctrl_cnt + 1'b1;
      end
    end
  end

  assign bus.data_stall_cnt = r_data_cnt;
  assign bus.ctrl_stall_cnt = r_ctrl_cnt;
  assign bus.hazard_err     = r_err;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Scoreboard bench for pipeline_stall_ctrl: a cycle model pushes expected outputs per driven cycle,
// which are popped and compared against the DUT mid-cycle, plus directed counter/flag checks.
module tb_pipeline_stall_ctrl;

  localparam int CALL_N = 2;
  localparam int RET_N  = 3;
  localparam int BR_N   = 2;
  localparam int CW     = 4;

  typedef struct packed {
    logic          pc;
    logic          we;
    logic          fl;
    logic          bb;
    logic          cc;
    logic          cr;
    logic          cb;
    logic [CW-1:0] dcnt;
    logic [CW-1:0] ccnt;
    logic          err;
    logic          known;
  } exp_t;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;
  int   n_brpulse;
  exp_t sb_q[$];

  // reference model state
  logic          m_wait;
  logic [3:0]    m_wc;
  logic [1:0]    m_ct;
  logic [CW-1:0] m_dcnt;
  logic [CW-1:0] m_ccnt;
  logic          m_err;
  logic          m_known;

  pipeline_stall_ctrl_if #(.CNT_W(CW)) bus ();

  pipeline_stall_ctrl #(
    .CALL_CYCLES  (CALL_N),
    .RET_CYCLES   (RET_N),
    .BRANCH_CYCLES(BR_N),
    .CNT_W        (CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle: drive, predict, compare at negedge, advance model at posedge.
  task automatic step(input logic r, input logic dh, input logic ch, input logic ca,
                      input logic rt, input logic br, input logic cl);
    exp_t e;
    exp_t o;
    logic last;
    rst = r;
    bus.data_hazard = dh; bus.control_hazard = ch;
    bus.call = ca; bus.ret = rt; bus.branch = br; bus.cnt_clr = cl;

    last = m_wait && (m_wc == 4'd0);
    e = '0;
    e.known = m_known;
    e.dcnt = m_dcnt; e.ccnt = m_ccnt; e.err = m_err;
    if (r) begin
      e.fl = 1'b1; e.bb = 1'b1;
    end else if (!m_wait) begin
      e.pc = !dh; e.we = !dh; e.bb = dh;
    end else begin
      e.fl = 1'b1; e.we = 1'b1; e.pc = last;
      e.cc = last && (m_ct == 2'd1);
      e.cr = last && (m_ct == 2'd2);
      e.cb = last && (m_ct == 2'd3);
    end
    sb_q.push_back(e);

    @(negedge clk);
    o = sb_q.pop_front();
    chk("pc_write_en",    32'(bus.pc_write_en),    32'(o.pc));
    chk("ifid_write_en",  32'(bus.ifid_write_en),  32'(o.we));
    chk("ifid_flush",     32'(bus.ifid_flush),     32'(o.fl));
    chk("idex_bubble",    32'(bus.idex_bubble),    32'(o.bb));
    chk("clr_call_haz",   32'(bus.clr_call_haz),   32'(o.cc));
    chk("clr_ret_haz",    32'(bus.clr_ret_haz),    32'(o.cr));
    chk("clr_branch_haz", 32'(bus.clr_branch_haz), 32'(o.cb));
    if (bus.clr_branch_haz === 1'b1) n_brpulse++;
    if (o.known) begin
      chk("data_stall_cnt", 32'(bus.data_stall_cnt), 32'(o.dcnt));
      chk("ctrl_stall_cnt", 32'(bus.ctrl_stall_cnt), 32'(o.ccnt));
      chk("hazard_err",     32'(bus.hazard_err),     32'(o.err));
    end

    @(posedge clk);
    if (r) begin
      m_wait = 1'b0; m_wc = 4'd0; m_ct = 2'd0;
      m_dcnt = '0; m_ccnt = '0; m_err = 1'b0; m_known = 1'b1;
    end else begin
      if (cl) begin
        m_dcnt = '0; m_ccnt = '0;
      end else begin
        if (!m_wait && dh && m_dcnt != '1) m_dcnt = m_dcnt + 1'b1;
        if (m_wait && m_ccnt != '1) m_ccnt = m_ccnt + 1'b1;
      end
      if (!m_wait) begin
        if (!dh && (ca || rt || br)) begin
          m_wait = 1'b1;
          if (rt)      begin m_ct = 2'd2; m_wc = 4'(RET_N - 1);  end
          else if (ca) begin m_ct = 2'd1; m_wc = 4'(CALL_N - 1); end
          else         begin m_ct = 2'd3; m_wc = 4'(BR_N - 1);   end
        end
      end else begin
        if (!ch) m_err = 1'b1;
        if (m_wc == 4'd0) m_wait = 1'b0;
        else m_wc = m_wc - 4'd1;
      end
    end
    #1;
  endtask

  initial begin
    n_chk = 0; n_fail = 0; n_brpulse = 0;
    m_wait = 1'b0; m_wc = '0; m_ct = '0; m_dcnt = '0; m_ccnt = '0; m_err = 1'b0; m_known = 1'b0;
    rst = 1'b1;
    bus.data_hazard = 1'b0; bus.control_hazard = 1'b0;
    bus.call = 1'b0; bus.ret = 1'b0; bus.branch = 1'b0; bus.cnt_clr = 1'b0;
    @(posedge clk); #1;

    // reset held two cycles, then release with no hazards
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    chk("rst_dcnt", 32'(bus.data_stall_cnt), 32'd0);
    chk("rst_ccnt", 32'(bus.ctrl_stall_cnt), 32'd0);
    chk("rst_err",  32'(bus.hazard_err),     32'd0);
    step(0, 0, 0, 0, 0, 0, 0);

    // three-cycle data stall
    repeat (3) step(0, 1, 0, 0, 0, 0, 0);
    chk("dstall_3", 32'(bus.data_stall_cnt), 32'd3);
    step(0, 0, 0, 0, 0, 0, 0);

    // call with control_hazard high during the wait
    step(0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0);
    chk("call_ccnt", 32'(bus.ctrl_stall_cnt), 32'd2);
    step(0, 0, 0, 0, 0, 0, 0);

    // ret+branch blocked by data hazard, ret wins once it drops
    n_brpulse = 0;
    step(0, 1, 0, 0, 1, 1, 0);
    step(0, 0, 0, 0, 1, 1, 0);
    repeat (3) step(0, 0, 1, 0, 1, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("no_branch_pulse", 32'(n_brpulse), 32'd0);
    chk("ret_ccnt", 32'(bus.ctrl_stall_cnt), 32'd5);

    // branch with missing control_hazard, then reset aborts the wait
    n_brpulse = 0;
    step(0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("err_set", 32'(bus.hazard_err), 32'd1);
    step(1, 0, 0, 0, 0, 0, 0);
    chk("err_clr", 32'(bus.hazard_err), 32'd0);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("abort_no_pulse", 32'(n_brpulse), 32'd0);

    // saturation and clear priority
    repeat (20) step(0, 1, 0, 0, 0, 0, 0);
    chk("dcnt_sat", 32'(bus.data_stall_cnt), 32'd15);
    step(0, 1, 0, 0, 0, 0, 1);
    chk("dcnt_clr", 32'(bus.data_stall_cnt), 32'd0);

    // random traffic with a well-behaved hazard detector
    for (int i = 0; i < 200; i++) begin
      logic [7:0] rv;
      rv = 8'($urandom);
      step(0, rv[0] & rv[1], m_wait, rv[2], rv[3] & rv[4], rv[5], (rv[7:6] == 2'b11) && rv[0]);
    end
    chk("rand_err", 32'(bus.hazard_err), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
